// File: rtl/fmadd_normalize_pipe.sv
// fmadd_normalize_pipe
//   Two-stage post-addition normalizer for the BF16 FMADD datapath.
//   Stage 1 captures the raw adder result and its leading-zero count;
//   stage 2 applies the carry right-shift or the clamped left-shift and
//   registers mantissa/exponent/GRS in the form the rounding stage expects.
// Ports
//   clk, rst_l                       clock, async active-low reset
//   in_valid/in_ready                upstream handshake
//   in_sum, in_sticky, in_exp,
//   in_sign, in_eff_sub, in_frm      raw adder result and context
//   out_valid/out_ready              downstream handshake
//   out_mantissa, out_exp, out_sign,
//   out_guard, out_round, out_sticky,
//   out_frm                          normalized result for rounding
module fmadd_normalize_pipe #(
  parameter int MAN = 6,
  parameter int EXP = 7
) (
  input  logic           clk,
  input  logic           rst_l,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [MAN+5:0] in_sum,
  input  logic           in_sticky,
  input  logic [EXP+1:0] in_exp,
  input  logic           in_sign,
  input  logic           in_eff_sub,
  input  logic [2:0]     in_frm,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [MAN+1:0] out_mantissa,
  output logic [EXP+1:0] out_exp,
  output logic           out_sign,
  output logic           out_guard,
  output logic           out_round,
  output logic           out_sticky,
  output logic [2:0]     out_frm
);
  localparam int SW  = MAN + 6;
  localparam int EW  = EXP + 2;
  localparam int LZW = $clog2(SW);

  // vld_pipe[1] = stage 1 occupied, vld_pipe[2] = stage 2 occupied
  logic [2:1] vld_pipe;
  logic       s1_adv;

  assign s1_adv    = vld_pipe[1] & (~vld_pipe[2] | out_ready);
  assign in_ready  = ~vld_pipe[1] | s1_adv;
  assign out_valid = vld_pipe[2];

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      vld_pipe <= '0;
    end else begin
      if (in_ready)       vld_pipe[1] <= in_valid;
      if (s1_adv)         vld_pipe[2] <= 1'b1;
      else if (out_ready) vld_pipe[2] <= 1'b0;
    end
  end

  // Leading zeros counted from the integer bit down; all-zero gives SW-1.
  logic [LZW-1:0] lz;
  always_comb begin
    lz = LZW'(SW - 1);
    for (int i = 0; i <= MAN + 4; i++)
      if (in_sum[i]) lz = LZW'(MAN + 4 - i);
  end

  logic [SW-1:0]  s1_sum;
  logic           s1_sticky, s1_sign, s1_eff_sub;
  logic [EW-1:0]  s1_exp;
  logic [2:0]     s1_frm;
  logic [LZW-1:0] s1_lz;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      s1_sum     <= '0;
      s1_sticky  <= 1'b0;
      s1_sign    <= 1'b0;
      s1_eff_sub <= 1'b0;
      s1_exp     <= '0;
      s1_frm     <= '0;
      s1_lz      <= '0;
    end else if (in_valid && in_ready) begin
      s1_sum     <= in_sum;
      s1_sticky  <= in_sticky;
      s1_sign    <= in_sign;
      s1_eff_sub <= in_eff_sub;
      s1_exp     <= in_exp;
      s1_frm     <= in_frm;
      s1_lz      <= lz;
    end
  end

  // Left shift stops where the exponent would reach 1 so the result lands
  // on the subnormal encoding instead of underflowing the exponent.
  logic [EW-1:0]   lim, amt, lz_ext;
  logic [SW-2:0]   sh;
  logic [MAN+1:0]  n_man;
  logic [EW-1:0]   n_exp;
  logic            n_sign, n_g, n_r, n_st;

  always_comb begin
    lz_ext = {{(EW - LZW){1'b0}}, s1_lz};
    lim    = (s1_exp == '0) ? '0 : s1_exp - EW'(1);
    amt    = (lz_ext < lim) ? lz_ext : lim;
    sh     = s1_sum[SW-2:0] << amt;
  end

  always_comb begin
    n_sign = s1_sign;
    n_man  = '0;
    n_exp  = '0;
    n_g    = 1'b0;
    n_r    = 1'b0;
    n_st   = 1'b0;
    if (s1_sum == '0 && !s1_sticky) begin
      // exact cancellation: sign follows the rounding mode (RDN -> -0)
      if (s1_eff_sub) n_sign = (s1_frm == 3'b010);
    end else if (s1_sum[SW-1]) begin
      n_man = s1_sum[SW-1:4];
      n_g   = s1_sum[3];
      n_r   = s1_sum[2];
      n_st  = |s1_sum[1:0] | s1_sticky;
      n_exp = s1_exp + EW'(1);
    end else begin
      // normal case is the amt=0 instance of the left-shift path
      n_man = sh[MAN+4:3];
      n_g   = sh[2];
      n_r   = sh[1];
      n_st  = sh[0] | s1_sticky;
      n_exp = sh[MAN+4] ? s1_exp - amt : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      out_mantissa <= '0;
      out_exp      <= '0;
      out_sign     <= 1'b0;
      out_guard    <= 1'b0;
      out_round    <= 1'b0;
      out_sticky   <= 1'b0;
      out_frm      <= '0;
    end else if (s1_adv) begin
      out_mantissa <= n_man;
      out_exp      <= n_exp;
      out_sign     <= n_sign;
      out_guard    <= n_g;
      out_round    <= n_r;
      out_sticky   <= n_st;
      out_frm      <= s1_frm;
    end
  end
endmodule

// File: tb/tb_fmadd_normalize_pipe.sv
// Randomized + directed bench for fmadd_normalize_pipe with a scoreboard
// fed by an iterative (shift-one-bit-at-a-time) normalization model.
module tb_fmadd_normalize_pipe;
  logic        clk = 1'b0;
  logic        rst_l = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [11:0] in_sum = '0;
  logic        in_sticky = 1'b0;
  logic [8:0]  in_exp = '0;
  logic        in_sign = 1'b0;
  logic        in_eff_sub = 1'b0;
  logic [2:0]  in_frm = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [7:0]  out_mantissa;
  logic [8:0]  out_exp;
  logic        out_sign, out_guard, out_round, out_sticky;
  logic [2:0]  out_frm;

  always #5 clk = ~clk;

  fmadd_normalize_pipe dut (
    .clk(clk), .rst_l(rst_l),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sum(in_sum), .in_sticky(in_sticky), .in_exp(in_exp),
    .in_sign(in_sign), .in_eff_sub(in_eff_sub), .in_frm(in_frm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_mantissa(out_mantissa), .out_exp(out_exp), .out_sign(out_sign),
    .out_guard(out_guard), .out_round(out_round), .out_sticky(out_sticky),
    .out_frm(out_frm)
  );

  typedef struct packed {
    logic [7:0] m;
    logic [8:0] e;
    logic       sg, g, r, st;
    logic [2:0] frm;
  } beat_t;

  beat_t q[$];
  int n_chk = 0, n_err = 0;
  int cyc = 0, n_emit = 0, or_mode = 0, bp_base = 0;
  bit saw_stall = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, want);
    end
  endtask

  // Reference: normalize one bit at a time until the integer bit is set
  // or the exponent has reached 1.
  function automatic beat_t model(input logic [11:0] sum, input logic sti,
                                  input logic [8:0] ein, input logic sg,
                                  input logic es, input logic [2:0] frm);
    beat_t b;
    int s = int'(sum);
    int e = int'(ein);
    b = '0;
    b.frm = frm;
    b.sg  = sg;
    if (s == 0 && !sti) begin
      b.sg = es ? (frm == 3'b010) : sg;
    end else if (s >= 2048) begin
      b.m  = 8'(s >> 4);
      b.g  = 1'((s >> 3) & 1);
      b.r  = 1'((s >> 2) & 1);
      b.st = ((s & 3) != 0) || sti;
      b.e  = 9'(e + 1);
    end else begin
      while (s != 0 && s < 1024 && e > 1) begin
        s = s * 2;
        e = e - 1;
      end
      b.m  = 8'(s >> 3);
      b.g  = 1'((s >> 2) & 1);
      b.r  = 1'((s >> 1) & 1);
      b.st = ((s & 1) != 0) || sti;
      b.e  = (s >= 1024) ? 9'(e) : 9'd0;
    end
    return b;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    case (or_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom_range(0, 3) != 0);
      2:       out_ready = !((cyc - bp_base) >= 2 && (cyc - bp_base) <= 5);
      default: out_ready = 1'b0;
    endcase
  end

  // Scoreboard: inputs and outputs are stable between posedge+1 and the
  // next posedge, so a negedge sample shows exactly what transfers next.
  always @(negedge clk) begin
    if (rst_l) begin
      if (in_valid && !in_ready) saw_stall = 1;
      if (in_valid && in_ready)
        q.push_back(model(in_sum, in_sticky, in_exp, in_sign, in_eff_sub, in_frm));
      if (out_valid && out_ready) begin
        n_emit++;
        if (q.size() == 0) chk("unexpected_beat", 32'd1, 32'd0);
        else chk("beat", {8'd0, out_mantissa, out_exp, out_sign, out_guard,
                          out_round, out_sticky, out_frm}, {8'd0, q.pop_front()});
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic send(input logic [11:0] s, input logic sti, input logic [8:0] e,
                      input logic sg, input logic es, input logic [2:0] frm);
    int w = 0;
    in_sum = s; in_sticky = sti; in_exp = e;
    in_sign = sg; in_eff_sub = es; in_frm = frm;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    while (q.size() != 0 && w < 300) begin
      @(posedge clk);
      w++;
    end
    #1;
    chk("drain", q.size(), 32'd0);
  endtask

  task automatic dir(input string tag, input logic [11:0] s, input logic sti,
                     input logic [8:0] e, input logic sg, input logic es,
                     input logic [2:0] frm, input logic [7:0] wm,
                     input logic [8:0] we, input logic wsg, input logic [2:0] wgrs);
    int lat = 0;
    send(s, sti, e, sg, es, frm);
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 50);
    chk({tag, ".lat"}, lat, 32'd2);
    chk({tag, ".m"}, out_mantissa, wm);
    chk({tag, ".e"}, out_exp, we);
    chk({tag, ".sign"}, out_sign, wsg);
    chk({tag, ".grs"}, {out_guard, out_round, out_sticky}, wgrs);
    chk({tag, ".frm"}, out_frm, frm);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [11:0] rs;
    logic [8:0]  re;
    int          e0;

    // reset
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 32'd0);
    rst_l = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 32'd1);
    chk("rst_out_valid2", out_valid, 32'd0);
    chk("rst_out_data", {out_mantissa, out_exp}, 32'd0);
    @(posedge clk);
    #1;

    // directed values
    dir("carry",   12'hC0B, 1'b0, 9'h080, 1'b0, 1'b0, 3'b000, 8'hC0, 9'h081, 1'b0, 3'b101);
    dir("cancel",  12'h018, 1'b0, 9'h080, 1'b1, 1'b1, 3'b001, 8'hC0, 9'h07A, 1'b1, 3'b000);
    dir("subnorm", 12'h018, 1'b0, 9'h003, 1'b0, 1'b0, 3'b000, 8'h0C, 9'h000, 1'b0, 3'b000);
    dir("zero_rdn",12'h000, 1'b0, 9'h040, 1'b0, 1'b1, 3'b010, 8'h00, 9'h000, 1'b1, 3'b000);
    dir("zero_rne",12'h000, 1'b0, 9'h040, 1'b1, 1'b1, 3'b000, 8'h00, 9'h000, 1'b0, 3'b000);
    dir("exp_ovf", 12'h800, 1'b0, 9'h0FF, 1'b0, 1'b0, 3'b100, 8'h80, 9'h100, 1'b0, 3'b000);
    dir("exp0",    12'h018, 1'b0, 9'h000, 1'b1, 1'b0, 3'b011, 8'h03, 9'h000, 1'b1, 3'b000);
    dir("sticky0", 12'h000, 1'b1, 9'h050, 1'b0, 1'b1, 3'b010, 8'h00, 9'h000, 1'b0, 3'b001);
    dir("normal",  12'h40F, 1'b0, 9'h010, 1'b1, 1'b0, 3'b000, 8'h81, 9'h010, 1'b1, 3'b111);
    drain();

    // backpressure: 4 back-to-back beats, out_ready low relative cycles 2-5
    e0 = n_emit;
    saw_stall = 0;
    bp_base = cyc;
    or_mode = 2;
    for (int i = 0; i < 4; i++)
      send(12'h400 | 12'(i * 16 + 5), 1'b0, 9'(16 + i), i[0], 1'b0, 3'(i));
    drain();
    chk("bp_emits", n_emit - e0, 32'd4);
    chk("bp_in_ready_drop", saw_stall, 32'd1);
    or_mode = 0;

    // randomized traffic with random backpressure
    or_mode = 1;
    for (int i = 0; i < 400; i++) begin
      rs = 12'($urandom);
      rs = rs >> $urandom_range(0, 11);
      if ($urandom_range(0, 19) == 0) rs = '0;
      case ($urandom_range(0, 5))
        0:       re = 9'd0;
        1:       re = 9'd1;
        2:       re = 9'($urandom_range(2, 11));
        3:       re = 9'd255;
        default: re = 9'($urandom_range(0, 255));
      endcase
      send(rs, 1'($urandom), re, 1'($urandom), 1'($urandom), 3'($urandom));
    end
    or_mode = 0;
    drain();

    // reset with both stages full
    or_mode = 3;
    @(posedge clk);
    #1;
    send(12'h123, 1'b0, 9'h020, 1'b0, 1'b0, 3'b000);
    send(12'h456, 1'b1, 9'h030, 1'b1, 1'b0, 3'b001);
    @(negedge clk);
    chk("mid_full", out_valid, 32'd1);
    #2;
    rst_l = 1'b0;
    #1;
    chk("mid_rst_async", out_valid, 32'd0);
    q.delete();
    or_mode = 0;
    @(posedge clk);
    #1;
    rst_l = 1'b1;
    e0 = n_emit;
    repeat (6) @(posedge clk);
    #1;
    chk("mid_no_stale", n_emit - e0, 32'd0);
    chk("mid_out_valid", out_valid, 32'd0);

    // pipeline still works after the reset
    dir("post_rst", 12'hC0B, 1'b0, 9'h080, 1'b0, 1'b0, 3'b000, 8'hC0, 9'h081, 1'b0, 3'b101);
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
